// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one external combinational ALU between two requesters
// (port 0 = EX stage, port 1 = address/branch helper). Round-robin
// arbitration picks one request and registers its operands onto the ALU
// inputs. The next cycle captures the ALU result into response registers,
// and the cycle after that the response is offered to the owning port.
// One operation is in flight at a time, so throughput is at best 1 op per
// 3 cycles.
//
// Handshake rule (both sides): a transfer happens on a rising clock edge
// where valid and ready are both 1. A requester keeps req_valid and its
// operands stable until req_ready is seen. The arbiter keeps rsp_valid and
// all rsp_* outputs stable until rsp_ready of the owning port is seen.
//
// Ports
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   req_valid[1:0]            per-port request valid
//   req_ready[1:0]            per-port request accept (one-hot or zero)
//   req_src1_x/req_src2_x     port x operands
//   req_ctrl_x                port x ALU op (legal 0..8)
//   alu_src1/alu_src2         registered operands to the ALU
//   alu_ctrl                  registered op code to the ALU
//   alu_result/alu_zero       ALU outputs
//   rsp_valid[1:0]            per-port response valid (owner only)
//   rsp_ready[1:0]            per-port response accept
//   rsp_result/rsp_zero       captured result and zero flag
//   rsp_err                   1 = op code was illegal; result forced to 0
//   dbg_state                 current FSM state (0 IDLE, 1 EXEC, 2 RESP)
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [WIDTH-1:0]  req_src1_0,
    input  logic [WIDTH-1:0]  req_src2_0,
    input  logic [CTRL_W-1:0] req_ctrl_0,
    input  logic [WIDTH-1:0]  req_src1_1,
    input  logic [WIDTH-1:0]  req_src2_1,
    input  logic [CTRL_W-1:0] req_ctrl_1,
    output logic [WIDTH-1:0]  alu_src1,
    output logic [WIDTH-1:0]  alu_src2,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_zero,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [WIDTH-1:0]  rsp_result,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic [1:0]        dbg_state
);

    // Highest legal op code (SRA); anything above is reported as an error.
    localparam logic [CTRL_W-1:0] LAST_OP = CTRL_W'(8);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic [WIDTH-1:0]  src1_q, src1_d;
    logic [WIDTH-1:0]  src2_q, src2_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              zero_q, zero_d;
    logic              err_q, err_d;

    logic              winner;
    logic              exec_err;

    // Round-robin pick: a lone requester always wins; on a tie the port
    // that was not served last time wins.
    always_comb begin
        winner = 1'b0;
        case (req_valid)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_grant_q;
            default: winner = 1'b0;
        endcase
    end

    assign exec_err = (ctrl_q > LAST_OP);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        src1_d       = src1_q;
        src2_d       = src2_q;
        ctrl_d       = ctrl_q;
        result_d     = result_q;
        zero_d       = zero_q;
        err_d        = err_q;
        req_ready    = 2'b00;
        rsp_valid    = 2'b00;

        case (state_q)
            S_IDLE: begin
                // Ready is only raised towards a valid port, so any ready
                // here is also a completed handshake.
                if (req_valid != 2'b00) begin
                    req_ready    = winner ? 2'b10 : 2'b01;
                    src1_d       = winner ? req_src1_1 : req_src1_0;
                    src2_d       = winner ? req_src2_1 : req_src2_0;
                    ctrl_d       = winner ? req_ctrl_1 : req_ctrl_0;
                    owner_d      = winner;
                    last_grant_d = winner;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                // An illegal op reports result 0 with zero set, whatever the
                // ALU produced for it.
                result_d = exec_err ? '0 : alu_result;
                zero_d   = exec_err ? 1'b1 : alu_zero;
                err_d    = exec_err;
                state_d  = S_RESP;
            end
            S_RESP: begin
                rsp_valid = owner_q ? 2'b10 : 2'b01;
                if (rsp_ready[owner_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            src1_q       <= '0;
            src2_q       <= '0;
            ctrl_q       <= '0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            src1_q       <= src1_d;
            src2_q       <= src2_d;
            ctrl_q       <= ctrl_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
            err_q        <= err_d;
        end
    end

    assign alu_src1   = src1_q;
    assign alu_src2   = src2_q;
    assign alu_ctrl   = ctrl_q;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign rsp_err    = err_q;
    assign dbg_state  = state_q;

endmodule
